// File: rtl/ysyx_25020047_mc_ctrl.sv
// Multi-cycle NPC sequencer: fetch/decode/exec/mem/writeback with handshake watchdog and halt.
// Optional perf counters are built only when YSYX_25020047_PERF_CNT_EN is defined.
module ysyx_25020047_mc_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_W          = 64
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ifu_req_valid,
   input  logic             ifu_rsp_valid,
   output logic             inst_latch_en,
   input  logic             dec_is_mem,
   input  logic             dec_is_ebreak,
   input  logic             dec_is_illegal,
   input  logic             dec_rd_wen,
   output logic             lsu_req_valid,
   input  logic             lsu_req_ready,
   input  logic             lsu_rsp_valid,
   output logic             reg_wen,
   output logic             pc_wen,
   output logic             halt,
   output logic [1:0]       halt_code,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   typedef enum logic [2:0] {
      StIdle, StFetch, StDecode, StExec, StMemReq, StMemWait, StWb, StHalt
   } state_e;

   localparam int unsigned WdW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WdW-1:0] WdMax = (TIMEOUT_CYCLES > 0) ? WdW'(TIMEOUT_CYCLES - 1) : '0;

   state_e         state_q, state_d;
   logic [1:0]     code_q, code_d;
   logic [WdW-1:0] wd_q, wd_d;
   logic           wd_expired;
   logic           waiting;

   assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_q == WdMax);
   assign waiting    = (state_q == StFetch) || (state_q == StMemReq) || (state_q == StMemWait);

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      unique case (state_q)
         StIdle:   state_d = StFetch;
         StFetch: begin
            if (ifu_rsp_valid) begin
               state_d = StDecode;
            end else if (wd_expired) begin
               state_d = StHalt;
               code_d  = 2'd2;
            end
         end
         StDecode: begin
            // Illegal outranks ebreak when the decoder flags both.
            if (dec_is_illegal) begin
               state_d = StHalt;
               code_d  = 2'd1;
            end else if (dec_is_ebreak) begin
               state_d = StHalt;
               code_d  = 2'd0;
            end else begin
               state_d = StExec;
            end
         end
         StExec:   state_d = dec_is_mem ? StMemReq : StWb;
         StMemReq: begin
            if (lsu_req_ready) begin
               state_d = lsu_rsp_valid ? StWb : StMemWait;
            end else if (wd_expired) begin
               state_d = StHalt;
               code_d  = 2'd3;
            end
         end
         StMemWait: begin
            if (lsu_rsp_valid) begin
               state_d = StWb;
            end else if (wd_expired) begin
               state_d = StHalt;
               code_d  = 2'd3;
            end
         end
         StWb:     state_d = StFetch;
         StHalt:   state_d = StHalt;
      endcase
   end

   // Any state change means the awaited event (or a halt) happened, so the count restarts.
   always_comb begin
      wd_d = '0;
      if (state_d == state_q && waiting && TIMEOUT_CYCLES != 0) begin
         wd_d = wd_q + WdW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         code_q  <= 2'd0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         wd_q    <= wd_d;
      end
   end

   assign ifu_req_valid = (state_q == StFetch);
   assign inst_latch_en = (state_q == StFetch) && ifu_rsp_valid;
   assign lsu_req_valid = (state_q == StMemReq);
   assign reg_wen       = (state_q == StWb) && dec_rd_wen;
   assign pc_wen        = (state_q == StWb);
   assign halt          = (state_q == StHalt);
   assign halt_code     = code_q;

`ifdef YSYX_25020047_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_q, instret_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if (state_q != StHalt) cycle_q <= cycle_q + CNT_W'(1);
         if (state_q == StWb) instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_25020047_mc_ctrl.sv
// Scoreboard bench for ysyx_25020047_mc_ctrl: each scenario queues per-cycle stimulus and
// expected outputs/counters, then replays them against the DUT.
module tb_ysyx_25020047_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_rsp_valid, inst_latch_en;
   logic        dec_is_mem, dec_is_ebreak, dec_is_illegal, dec_rd_wen;
   logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
   logic        reg_wen, pc_wen, halt;
   logic [1:0]  halt_code;
   logic [63:0] cycle_cnt, instret_cnt;
   logic [7:0]  outs;

   always #5 clk = ~clk;

   ysyx_25020047_mc_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req_valid (ifu_req_valid),
      .ifu_rsp_valid (ifu_rsp_valid),
      .inst_latch_en (inst_latch_en),
      .dec_is_mem    (dec_is_mem),
      .dec_is_ebreak (dec_is_ebreak),
      .dec_is_illegal(dec_is_illegal),
      .dec_rd_wen    (dec_rd_wen),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_ready (lsu_req_ready),
      .lsu_rsp_valid (lsu_rsp_valid),
      .reg_wen       (reg_wen),
      .pc_wen        (pc_wen),
      .halt          (halt),
      .halt_code     (halt_code),
      .cycle_cnt     (cycle_cnt),
      .instret_cnt   (instret_cnt)
   );

   assign outs = {ifu_req_valid, inst_latch_en, lsu_req_valid, reg_wen, pc_wen, halt, halt_code};

   // Output vectors: {ifu_req, latch, lsu_req, reg_wen, pc_wen, halt, code[1:0]}
   localparam logic [7:0] O_Z   = 8'h00;
   localparam logic [7:0] O_F   = 8'h80;
   localparam logic [7:0] O_FL  = 8'hC0;
   localparam logic [7:0] O_M   = 8'h20;
   localparam logic [7:0] O_WBR = 8'h18;
   localparam logic [7:0] O_WB  = 8'h08;
   localparam logic [7:0] O_H0  = 8'h04;
   localparam logic [7:0] O_H1  = 8'h05;
   localparam logic [7:0] O_H2  = 8'h06;
   localparam logic [7:0] O_H3  = 8'h07;
   // Stimulus vectors: {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid}
   localparam logic [2:0] NONE = 3'b000;
   localparam logic [2:0] IRSP = 3'b100;
   localparam logic [2:0] RDY  = 3'b010;
   localparam logic [2:0] LRSP = 3'b001;

   typedef struct {
      logic [2:0]  stim;
      logic [7:0]  exp;
      logic [63:0] cyc;
      logic [63:0] ret;
   } ent_t;

   ent_t        plan_q[$];
   logic [63:0] m_cyc, m_ret;
   int          checks = 0;
   int          errors = 0;

   // Counter expectations follow the architectural rules: cycles count while not halted,
   // retirements count on each writeback (pc_wen) cycle.
   task automatic push(input logic [2:0] stim, input logic [7:0] exp);
      ent_t e;
      e.stim = stim;
      e.exp  = exp;
`ifdef YSYX_25020047_PERF_CNT_EN
      e.cyc = m_cyc;
      e.ret = m_ret;
`else
      e.cyc = 64'd0;
      e.ret = 64'd0;
`endif
      if (!exp[2]) m_cyc = m_cyc + 64'd1;
      if (exp[3]) m_ret = m_ret + 64'd1;
      plan_q.push_back(e);
   endtask

   task automatic set_dec(input logic mem, input logic ebr, input logic ill, input logic rdw);
      dec_is_mem     = mem;
      dec_is_ebreak  = ebr;
      dec_is_illegal = ill;
      dec_rd_wen     = rdw;
   endtask

   // Leaves the bench at posedge+1 of the first post-reset (IDLE) cycle.
   task automatic do_reset();
      rst = 1'b1;
      {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = NONE;
      plan_q.delete();
      m_cyc = 64'd0;
      m_ret = 64'd0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = IRSP | RDY | LRSP;
      set_dec(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (outs !== O_Z || cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
            errors++;
            $display("FAIL reset cycle %0d: got outs=%b cyc=%0d ret=%0d, want outs=%b cyc=0 ret=0",
                     i, outs, cycle_cnt, instret_cnt, O_Z);
         end
      end
      rst = 1'b0;
      {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = NONE;
      m_cyc = 64'd0;
      m_ret = 64'd0;
      push(NONE, O_Z);
      push(NONE, O_F);
      for (int step = 0; plan_q.size() != 0; step++) begin
         ent_t e = plan_q.pop_front();
         {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = e.stim;
         @(negedge clk);
         checks++;
         if (outs !== e.exp || cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
            errors++;
            $display("FAIL reset_release step %0d: got outs=%b cyc=%0d ret=%0d, want outs=%b cyc=%0d ret=%0d",
                     step, outs, cycle_cnt, instret_cnt, e.exp, e.cyc, e.ret);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_alu();
      set_dec(1'b0, 1'b0, 1'b0, 1'b1);
      do_reset();
      push(NONE, O_Z);
      push(NONE, O_F);
      push(IRSP, O_FL);
      push(NONE, O_Z);
      push(NONE, O_Z);
      push(NONE, O_WBR);
      push(NONE, O_F);
      for (int step = 0; plan_q.size() != 0; step++) begin
         ent_t e = plan_q.pop_front();
         {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = e.stim;
         @(negedge clk);
         checks++;
         if (outs !== e.exp || cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
            errors++;
            $display("FAIL alu step %0d: got outs=%b cyc=%0d ret=%0d, want outs=%b cyc=%0d ret=%0d",
                     step, outs, cycle_cnt, instret_cnt, e.exp, e.cyc, e.ret);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_load();
      set_dec(1'b1, 1'b0, 1'b0, 1'b1);
      do_reset();
      push(NONE, O_Z);
      push(IRSP, O_FL);
      push(IRSP, O_Z);          // stray fetch response in DECODE is ignored
      push(LRSP, O_Z);          // stray LSU response in EXEC is ignored
      push(NONE, O_M);
      push(NONE, O_M);
      push(RDY, O_M);
      push(NONE, O_Z);
      push(NONE, O_Z);
      push(LRSP, O_Z);
      push(NONE, O_WBR);
      push(NONE, O_F);
      for (int step = 0; plan_q.size() != 0; step++) begin
         ent_t e = plan_q.pop_front();
         {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = e.stim;
         @(negedge clk);
         checks++;
         if (outs !== e.exp || cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
            errors++;
            $display("FAIL load step %0d: got outs=%b cyc=%0d ret=%0d, want outs=%b cyc=%0d ret=%0d",
                     step, outs, cycle_cnt, instret_cnt, e.exp, e.cyc, e.ret);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_store();
      set_dec(1'b1, 1'b0, 1'b0, 1'b0);
      do_reset();
      push(NONE, O_Z);
      push(IRSP, O_FL);
      push(NONE, O_Z);
      push(NONE, O_Z);
      push(RDY | LRSP, O_M);
      push(NONE, O_WB);
      push(NONE, O_F);
      for (int step = 0; plan_q.size() != 0; step++) begin
         ent_t e = plan_q.pop_front();
         {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = e.stim;
         @(negedge clk);
         checks++;
         if (outs !== e.exp || cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
            errors++;
            $display("FAIL store step %0d: got outs=%b cyc=%0d ret=%0d, want outs=%b cyc=%0d ret=%0d",
                     step, outs, cycle_cnt, instret_cnt, e.exp, e.cyc, e.ret);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      set_dec(1'b0, 1'b0, 1'b0, 1'b1);
      do_reset();
      push(NONE, O_Z);
      for (int i = 0; i < 3; i++) begin
         push(IRSP, O_FL);
         push(NONE, O_Z);
         push(NONE, O_Z);
         push(NONE, O_WBR);
      end
      push(NONE, O_F);
      for (int step = 0; plan_q.size() != 0; step++) begin
         ent_t e = plan_q.pop_front();
         {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = e.stim;
         @(negedge clk);
         checks++;
         if (outs !== e.exp || cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
            errors++;
            $display("FAIL back_to_back step %0d: got outs=%b cyc=%0d ret=%0d, want outs=%b cyc=%0d ret=%0d",
                     step, outs, cycle_cnt, instret_cnt, e.exp, e.cyc, e.ret);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_halt(input logic ill, input logic [7:0] hexp);
      set_dec(1'b0, 1'b1, ill, 1'b1);
      do_reset();
      push(NONE, O_Z);
      push(IRSP, O_FL);
      push(NONE, O_Z);
      push(IRSP, hexp);
      push(RDY | LRSP, hexp);
      push(IRSP | RDY | LRSP, hexp);
      push(NONE, hexp);
      for (int step = 0; plan_q.size() != 0; step++) begin
         ent_t e = plan_q.pop_front();
         {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = e.stim;
         @(negedge clk);
         checks++;
         if (outs !== e.exp || cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
            errors++;
            $display("FAIL halt(ill=%0d) step %0d: got outs=%b cyc=%0d ret=%0d, want outs=%b cyc=%0d ret=%0d",
                     ill, step, outs, cycle_cnt, instret_cnt, e.exp, e.cyc, e.ret);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // kind 0: fetch timeout, 1: fetch rsp on the timeout cycle, 2: MEM_REQ timeout,
   // 3: MEM_WAIT timeout after a delayed accept.
   task automatic test_timeout(input int kind);
      set_dec(kind >= 2, 1'b0, 1'b0, 1'b1);
      do_reset();
      push(NONE, O_Z);
      if (kind == 0) begin
         for (int i = 0; i < 8; i++) push(NONE, O_F);
         push(IRSP, O_H2);
         push(NONE, O_H2);
      end else if (kind == 1) begin
         for (int i = 0; i < 7; i++) push(NONE, O_F);
         push(IRSP, O_FL);
         push(NONE, O_Z);
         push(NONE, O_Z);
         push(NONE, O_WBR);
         push(NONE, O_F);
      end else begin
         push(IRSP, O_FL);
         push(NONE, O_Z);
         push(NONE, O_Z);
         if (kind == 2) begin
            for (int i = 0; i < 8; i++) push(NONE, O_M);
         end else begin
            for (int i = 0; i < 3; i++) push(NONE, O_M);
            push(RDY, O_M);
            for (int i = 0; i < 8; i++) push(NONE, O_Z);
         end
         push(LRSP, O_H3);
         push(NONE, O_H3);
      end
      for (int step = 0; plan_q.size() != 0; step++) begin
         ent_t e = plan_q.pop_front();
         {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = e.stim;
         @(negedge clk);
         checks++;
         if (outs !== e.exp || cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
            errors++;
            $display("FAIL timeout(kind=%0d) step %0d: got outs=%b cyc=%0d ret=%0d, want outs=%b cyc=%0d ret=%0d",
                     kind, step, outs, cycle_cnt, instret_cnt, e.exp, e.cyc, e.ret);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_abort();
      set_dec(1'b1, 1'b0, 1'b0, 1'b1);
      do_reset();
      push(NONE, O_Z);
      push(IRSP, O_FL);
      push(NONE, O_Z);
      push(NONE, O_Z);
      push(RDY, O_M);
      for (int step = 0; plan_q.size() != 0; step++) begin
         ent_t e = plan_q.pop_front();
         {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = e.stim;
         @(negedge clk);
         @(posedge clk);
         #1;
      end
      // Now in MEM_WAIT: reset coincides with the load response, which must be dropped.
      rst = 1'b1;
      {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = LRSP;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_cyc = 64'd0;
      m_ret = 64'd0;
      push(LRSP, O_Z);
      push(NONE, O_F);
      for (int step = 0; plan_q.size() != 0; step++) begin
         ent_t e = plan_q.pop_front();
         {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = e.stim;
         @(negedge clk);
         checks++;
         if (outs !== e.exp || cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
            errors++;
            $display("FAIL reset_abort step %0d: got outs=%b cyc=%0d ret=%0d, want outs=%b cyc=%0d ret=%0d",
                     step, outs, cycle_cnt, instret_cnt, e.exp, e.cyc, e.ret);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      {ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid} = NONE;
      set_dec(1'b0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_back_to_back();
      test_halt(1'b0, O_H0);
      test_halt(1'b1, O_H1);
      test_timeout(0);
      test_timeout(1);
      test_timeout(2);
      test_timeout(3);
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
